wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Two-master, one-slave Wishbone arbiter sharing a single physical memory port between the pipeline's instruction-fetch master and data-access master. It sits between the cpu's `instruction_memory_wishbone` / `data_memory_wishbone` masters and the memory (or cache) slave. It grants one transaction at a time with round-robin fairness, steers request signals to the slave and ACK/RTY back to the owner only, and bounds slave latency with an optional watchdog.

## Interface
- `ADR_W`, default 12: line address width.
- `DAT_W`, default 128: data width.
- `SEL_W`, default 16: byte-select width (DAT_W/8).
- `TIMEOUT`, default 0: watchdog limit in granted cycles. 0 disables the watchdog. Legal range 0..65535.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_cyc`, `i_stb`, `i_we`  in  1 each  instruction master cycle, strobe and write enable.
- `i_sel`  in  SEL_W  instruction master byte selects.
- `i_adr`  in  ADR_W  instruction master address.
- `i_dat_m`  in  DAT_W  instruction master write data.
- `i_dat_s`  out  DAT_W  read data to the instruction master.
- `i_ack`, `i_rty`  out  1 each  acknowledge and retry to the instruction master.
- `d_*`  same set as `i_*`  data master.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to the slave.
- `s_sel`  out  SEL_W  to the slave.
- `s_adr`  out  ADR_W  to the slave.
- `s_dat_m`  out  DAT_W  to the slave.
- `s_dat_s`  in  DAT_W  read data from the slave.
- `s_ack`, `s_rty`  in  1 each  acknowledge and retry from the slave.
- `grant`  out  2  one-hot owner: bit0 = instruction, bit1 = data. 00 when idle.

## Operation
- A request is `x_cyc & x_stb`.
- FSM states are IDLE, GNT_I and GNT_D. The state is registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: go to that master's grant state.
  - Both request: grant the master that was not granted last. The `last` register resets to I, so D wins the first tie.
  - `last` updates on every entry into a grant state.
- GNT_x:
  - `s_cyc/s_stb/s_we/s_sel/s_adr/s_dat_m` are driven combinationally from master x.
  - `x_ack = s_ack`.
  - `x_rty = s_rty & ~s_ack`, or the watchdog retry (below).
  - The other master sees ack = rty = 0.
- Leaving GNT_x: return to IDLE on the clock after any of:
  - `s_ack`,
  - `s_rty`,
  - watchdog fire,
  - `x_cyc` deasserted (abort). On abort, `s_cyc`/`s_stb` follow `x_cyc` low in that same cycle. No ack is generated.
- In IDLE all slave outputs are 0, including address, data and sel.
- `i_dat_s` and `d_dat_s` both carry `s_dat_s` unconditionally. Masters qualify read data with their own ack.
- Watchdog (TIMEOUT > 0):
  - A 16-bit counter clears on entry to a grant state and increments every granted cycle without `s_ack`/`s_rty`.
  - In the granted cycle where count == TIMEOUT-1 and `s_ack`=`s_rty`=0, assert `x_rty` for that one cycle and return to IDLE.
  - `s_cyc` is still high in that cycle and drops the next cycle.
- A master holding `cyc/stb` after its ack is treated as a new request in IDLE and competes normally.
- Simultaneous `s_ack` and `s_rty`: ack wins, rty is suppressed.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `last` = I, counter 0. All outputs 0: `s_*`, `x_ack`, `x_rty`, `grant`. `x_dat_s` follows `s_dat_s`.
- Reset asserted mid-transaction: the bus drops immediately (`s_cyc`=0) and no ack or rty reaches either master.
- Arbitration latency:
  - Request sampled in IDLE at cycle 0.
  - Grant state and `s_stb` asserted at cycle 1.
  - Slave ack at cycle k (k ≥ 1) reaches the master in the same cycle k.
  - IDLE at k+1; earliest next grant at k+2.
- One idle bubble follows every transaction, which guarantees `s_cyc` low for at least one cycle between owners.
- `grant` is registered and equals the state encoding.

## Test plan
- Single instruction read: `i_cyc/i_stb`=1, `i_adr`=0x010, slave acks 3 cycles after `s_stb` with data 0xA5…A5.
  - `grant`=01 from cycle 1.
  - `s_adr`=0x010.
  - `i_ack`=1 with `i_dat_s`=0xA5…A5 in a single cycle.
  - `d_ack` stays 0.
  - IDLE the next cycle.
- Simultaneous requests from reset, both held:
  - Order of grants is D, I, D, I.
  - `s_cyc` low for exactly one cycle between each.
  - No master is granted twice in a row while the other waits.
- Data write, `d_we`=1, `d_sel`=0x000F, `d_dat_m`=0x1234: `s_we`=1, `s_sel`=0x000F, `s_dat_m`=0x1234 during GNT_D; `i_*` outputs stay 0.
- TIMEOUT=4 with a silent slave:
  - `d_rty` pulses in the 4th granted cycle.
  - IDLE next.
  - A pending instruction request is granted 1 cycle later.
- Abort: `i_cyc` drops 2 cycles into GNT_I → `s_cyc`=0 in the same cycle, IDLE next, no `i_ack`/`i_rty`.
- `rst_n` pulsed low mid GNT_D before ack → all outputs 0 immediately, `grant`=00. The first tie after release goes to D.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - two-master round-robin Wishbone arbiter with optional slave watchdog
//
// Shares one Wishbone slave port between the instruction-fetch master (i_*)
// and the data-access master (d_*). One transaction is granted at a time.
// Ties go to the master that was not granted last. A single idle cycle
// separates any two grants.
//
// Parameters
//   ADR_W    line address width
//   DAT_W    data width
//   SEL_W    byte-select width (DAT_W/8)
//   TIMEOUT  watchdog limit in granted cycles, 0 disables (0..65535)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we/i_sel/i_adr    instruction master request
//   i_dat_m / i_dat_s               instruction master write / read data
//   i_ack / i_rty                   instruction master acknowledge / retry
//   d_*                             same set for the data master
//   s_cyc/s_stb/s_we/s_sel/s_adr    request steered to the slave
//   s_dat_m / s_dat_s               slave write / read data
//   s_ack / s_rty                   slave acknowledge / retry
//   grant                           registered one-hot owner (bit0 I, bit1 D)

module wishbone_arbiter #(
    parameter int ADR_W   = 12,
    parameter int DAT_W   = 128,
    parameter int SEL_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_sel,
    input  logic [ADR_W-1:0] i_adr,
    input  logic [DAT_W-1:0] i_dat_m,
    output logic [DAT_W-1:0] i_dat_s,
    output logic             i_ack,
    output logic             i_rty,

    input  logic             d_cyc,
    input  logic             d_stb,
    input  logic             d_we,
    input  logic [SEL_W-1:0] d_sel,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [DAT_W-1:0] d_dat_m,
    output logic [DAT_W-1:0] d_dat_s,
    output logic             d_ack,
    output logic             d_rty,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [SEL_W-1:0] s_sel,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_m,
    input  logic [DAT_W-1:0] s_dat_s,
    input  logic             s_ack,
    input  logic             s_rty,

    output logic [1:0]       grant
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_d;     // 1 when the data master owned the most recent grant
    logic   req_i;
    logic   req_d;
    logic   wd_fire;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign i_dat_s = s_dat_s;
    assign d_dat_s = s_dat_s;

    assign grant = state;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
            logic [15:0] wd_cnt;

            // Every grant is entered from IDLE, so holding the count at zero
            // while idle is the same as clearing it on grant entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt <= '0;
                end else if (state == IDLE) begin
                    wd_cnt <= '0;
                end else if (!s_ack && !s_rty) begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end

            // A real slave response in the same cycle always takes priority.
            assign wd_fire = (state != IDLE) && !s_ack && !s_rty && (wd_cnt == WD_LAST);
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                last_d <= (state_next == GNT_D);
            end
        end
    end

    always_comb begin
        state_next = state;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_sel      = '0;
        s_adr      = '0;
        s_dat_m    = '0;
        i_ack      = 1'b0;
        i_rty      = 1'b0;
        d_ack      = 1'b0;
        d_rty      = 1'b0;

        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_next = last_d ? GNT_I : GNT_D;
                end else if (req_i) begin
                    state_next = GNT_I;
                end else if (req_d) begin
                    state_next = GNT_D;
                end
            end

            GNT_I: begin
                // cyc passes straight through so an abort drops the bus this cycle.
                s_cyc   = i_cyc;
                s_stb   = i_stb;
                s_we    = i_we;
                s_sel   = i_sel;
                s_adr   = i_adr;
                s_dat_m = i_dat_m;
                i_ack   = s_ack;
                i_rty   = (s_rty & ~s_ack) | wd_fire;
                if (s_ack || s_rty || wd_fire || !i_cyc) begin
                    state_next = IDLE;
                end
            end

            GNT_D: begin
                s_cyc   = d_cyc;
                s_stb   = d_stb;
                s_we    = d_we;
                s_sel   = d_sel;
                s_adr   = d_adr;
                s_dat_m = d_dat_m;
                d_ack   = s_ack;
                d_rty   = (s_rty & ~s_ack) | wd_fire;
                if (s_ack || s_rty || wd_fire || !d_cyc) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - self-checking bench for wishbone_arbiter

module tb_wishbone_arbiter;

    localparam int ADR_W = 12;
    localparam int DAT_W = 128;
    localparam int SEL_W = 16;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_cyc, i_stb, i_we;
    logic [SEL_W-1:0] i_sel;
    logic [ADR_W-1:0] i_adr;
    logic [DAT_W-1:0] i_dat_m, i_dat_s;
    logic             i_ack, i_rty;
    logic             d_cyc, d_stb, d_we;
    logic [SEL_W-1:0] d_sel;
    logic [ADR_W-1:0] d_adr;
    logic [DAT_W-1:0] d_dat_m, d_dat_s;
    logic             d_ack, d_rty;
    logic             s_cyc, s_stb, s_we;
    logic [SEL_W-1:0] s_sel;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_m, s_dat_s;
    logic             s_ack, s_rty;
    logic [1:0]       grant;

    int checks   = 0;
    int failures = 0;
    bit model_last_d = 1'b0;   // reference: who won the most recent grant

    wishbone_arbiter #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_adr(i_adr),
        .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr),
        .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack), .s_rty(s_rty),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_req_i();
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'($urandom_range(1, 0));
        i_sel = 16'($urandom); i_adr = 12'($urandom); i_dat_m = rnd128();
    endtask

    task automatic new_req_d();
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'($urandom_range(1, 0));
        d_sel = 16'($urandom); d_adr = 12'($urandom); d_dat_m = rnd128();
    endtask

    // Entered just after a clock edge with the arbiter idle and this cycle's
    // requests already driven. Runs one arbitration + transaction and returns
    // one cycle after the response, with the winner's request withdrawn.
    // kind: 0 ack, 1 rty, 2 ack+rty together, 3 abort at abort_c (silent slave).
    // lat: granted cycle on which the slave responds.
    task automatic round(input int lat, input int kind, input int abort_c,
                         input logic [127:0] rdata, output logic [1:0] g_obs);
        logic [1:0]       win;
        bit               ri, rd, live, exp_ack, exp_rty;
        int               end_c;
        logic [ADR_W-1:0] w_adr;
        logic [SEL_W-1:0] w_sel;
        logic [DAT_W-1:0] w_dat;
        logic             w_we;
        #1;
        chk("idle_grant", 128'(grant), 128'(0));
        chk("idle_s_cyc", 128'(s_cyc), 128'(0));
        chk("idle_s_adr", 128'(s_adr), 128'(0));
        chk("idle_s_sel", 128'(s_sel), 128'(0));
        chk("idle_s_dat_m", s_dat_m, 128'(0));
        chk("idle_acks", 128'({i_ack, i_rty, d_ack, d_rty}), 128'(0));
        g_obs = 2'b00;
        ri = i_cyc & i_stb;
        rd = d_cyc & d_stb;
        if (!ri && !rd) begin
            tick();
            return;
        end
        if (ri && rd) win = model_last_d ? 2'b01 : 2'b10;
        else          win = ri ? 2'b01 : 2'b10;
        model_last_d = (win == 2'b10);
        w_adr = win[0] ? i_adr : d_adr;
        w_sel = win[0] ? i_sel : d_sel;
        w_dat = win[0] ? i_dat_m : d_dat_m;
        w_we  = win[0] ? i_we : d_we;
        end_c = (kind == 3) ? abort_c : ((lat <= TMO) ? lat : TMO);
        for (int c = 1; c <= end_c; c++) begin
            tick();
            s_dat_s = (c == end_c) ? rdata : rnd128();
            s_ack   = (kind != 3) && (c == lat) && (kind != 1);
            s_rty   = (kind != 3) && (c == lat) && (kind != 0);
            live    = !(kind == 3 && c == abort_c);
            if (!live) begin
                if (win[0]) begin i_cyc = 1'b0; i_stb = 1'b0; end
                else        begin d_cyc = 1'b0; d_stb = 1'b0; end
            end
            #1;
            if (c == 1) g_obs = grant;
            exp_ack = (kind != 3) && (c == end_c) && (lat <= TMO) && (kind != 1);
            exp_rty = (kind != 3) && (c == end_c) && ((lat > TMO) || (kind == 1));
            chk("gnt_grant", 128'(grant), 128'(win));
            chk("gnt_s_cyc", 128'(s_cyc), 128'(live));
            chk("gnt_s_stb", 128'(s_stb), 128'(live));
            if (live) begin
                chk("gnt_s_adr", 128'(s_adr), 128'(w_adr));
                chk("gnt_s_sel", 128'(s_sel), 128'(w_sel));
                chk("gnt_s_we", 128'(s_we), 128'(w_we));
                chk("gnt_s_dat_m", s_dat_m, w_dat);
            end
            chk("owner_ack", 128'(win[0] ? i_ack : d_ack), 128'(exp_ack));
            chk("owner_rty", 128'(win[0] ? i_rty : d_rty), 128'(exp_rty));
            chk("other_ack_rty", 128'(win[0] ? {d_ack, d_rty} : {i_ack, i_rty}), 128'(0));
            chk("i_dat_s", i_dat_s, s_dat_s);
            chk("d_dat_s", d_dat_s, s_dat_s);
        end
        tick();
        s_ack = 1'b0;
        s_rty = 1'b0;
        if (win[0]) begin i_cyc = 1'b0; i_stb = 1'b0; end
        else        begin d_cyc = 1'b0; d_stb = 1'b0; end
    endtask

    initial begin : stim
        logic [1:0]   g;
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        rst_n = 1'b0;
        i_cyc = 0; i_stb = 0; i_we = 0; i_sel = '0; i_adr = '0; i_dat_m = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0; d_adr = '0; d_dat_m = '0;
        s_ack = 0; s_rty = 0; s_dat_s = rnd128();

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_s_bus", 128'({s_cyc, s_stb, s_we, s_sel, s_adr}), 128'(0));
        chk("rst_acks", 128'({i_ack, i_rty, d_ack, d_rty}), 128'(0));
        chk("rst_i_dat_s", i_dat_s, s_dat_s);
        tick();
        rst_n = 1'b1;

        // Single instruction read, slave acks on the 4th granted cycle
        i_cyc = 1; i_stb = 1; i_we = 0; i_sel = 16'hFFFF; i_adr = 12'h010; i_dat_m = '0;
        round(4, 0, 0, a5, g);
        chk("rd_grant_i", 128'(g), 128'(2'b01));

        // Data write
        d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 16'h000F; d_adr = 12'h020; d_dat_m = 128'h1234;
        round(2, 0, 0, rnd128(), g);
        chk("wr_grant_d", 128'(g), 128'(2'b10));

        // Reset pulsed mid GNT_D with the slave acking
        d_cyc = 1; d_stb = 1; d_we = 0; d_adr = 12'h3C0;
        tick();
        #1;
        chk("mid_grant_d", 128'(grant), 128'(2'b10));
        tick();
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        model_last_d = 1'b0;
        chk("mid_rst_s_cyc", 128'(s_cyc), 128'(0));
        chk("mid_rst_grant", 128'(grant), 128'(0));
        chk("mid_rst_acks", 128'({i_ack, i_rty, d_ack, d_rty}), 128'(0));
        tick();
        s_ack = 1'b0;
        rst_n = 1'b1;

        // Both held from reset: D, I, D, I
        new_req_i();
        round(1, 0, 0, rnd128(), g); chk("tie1_d", 128'(g), 128'(2'b10));
        new_req_d();
        round(2, 0, 0, rnd128(), g); chk("tie2_i", 128'(g), 128'(2'b01));
        new_req_i();
        round(1, 2, 0, rnd128(), g); chk("tie3_d", 128'(g), 128'(2'b10));
        new_req_d();
        round(3, 1, 0, rnd128(), g); chk("tie4_i", 128'(g), 128'(2'b01));

        // Watchdog: silent slave on D with I pending, then I served right after
        new_req_i();
        round(7, 0, 0, rnd128(), g); chk("wd_grant_d", 128'(g), 128'(2'b10));
        round(1, 0, 0, rnd128(), g); chk("wd_next_i", 128'(g), 128'(2'b01));

        // Abort two cycles into GNT_I
        new_req_i();
        round(7, 3, 2, rnd128(), g); chk("abort_grant_i", 128'(g), 128'(2'b01));

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            if (!i_cyc && $urandom_range(1, 0) == 1) new_req_i();
            if (!d_cyc && $urandom_range(1, 0) == 1) new_req_d();
            round(int'($urandom_range(6, 1)), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 1)), rnd128(), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
